// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Purpose  : Push-button front end. Two-flop synchroniser, per-channel
//            debounce, press-pulse generation with lowest-index arbitration
//            and optional auto-repeat on held buttons.
// Options  : BTN_AUTOREPEAT_EN - when defined, channels selected by
//            REPEAT_MASK emit repeat pulses while held.
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter int               REPEAT_DELAY    = 50000000,
    parameter int               REPEAT_RATE     = 12500000,
    parameter logic [WIDTH-1:0] REPEAT_MASK     = 4'b1010
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_pulse,
    output logic [WIDTH-1:0] btn_level
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    // Reject parameter sets the counters cannot honour.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_RATE < 2 ||
        $bits(REPEAT_MASK) != WIDTH) begin : g_param_check
        $error("btn_conditioner: parameter out of range");
    end

    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] cand;

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= btn_raw;
            sync      <= sync_meta;
        end
    end

    // btn_level is the debounced level delayed by one cycle, so comparing the
    // two gives the debounced rising edge without an extra register.
    assign rise = level & ~btn_level;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [DB_W-1:0] db_cnt;
        logic            lvl;

        // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt <= '0;
                lvl    <= 1'b0;
            end else if (sync[i] == lvl) begin
                db_cnt <= '0;
            end else if (db_cnt >= DB_W'(DEBOUNCE_CYCLES - 1)) begin
                lvl    <= sync[i];
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end

        assign level[i] = lvl;
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int TM_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TM_W   = $clog2(TM_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    for (genvar i = 0; i < WIDTH; i++) begin : g_repeat
        if (REPEAT_MASK[i]) begin : g_rep
            rep_state_t      state;
            rep_state_t      state_nx;
            logic [TM_W-1:0] timer;
            logic [TM_W-1:0] timer_nx;
            logic            rep_cand;

            // Repeat state and countdown timer.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state <= IDLE;
                    timer <= '0;
                end else begin
                    state <= state_nx;
                    timer <= timer_nx;
                end
            end

            // Timer value 1 marks expiry so the pulse registers exactly
            // REPEAT_DELAY / REPEAT_RATE cycles after the previous one.
            always_comb begin
                state_nx = state;
                timer_nx = timer;
                rep_cand = 1'b0;
                case (state)
                    IDLE: begin
                        if (rise[i]) begin
                            rep_cand = 1'b1;
                            timer_nx = TM_W'(REPEAT_DELAY);
                            state_nx = HELD;
                        end
                    end
                    HELD, REPEAT: begin
                        if (!level[i]) begin
                            state_nx = IDLE;
                            timer_nx = '0;
                        end else if (timer == TM_W'(1)) begin
                            rep_cand = 1'b1;
                            timer_nx = TM_W'(REPEAT_RATE);
                            state_nx = REPEAT;
                        end else if (timer != '0) begin
                            timer_nx = timer - TM_W'(1);
                        end
                    end
                    default: begin
                        state_nx = IDLE;
                        timer_nx = '0;
                    end
                endcase
            end

            assign cand[i] = rep_cand;
        end else begin : g_norep
            assign cand[i] = rise[i];
        end
    end
`else
    assign cand = rise;
`endif

    // Issue only the lowest-index candidate; the others are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_pulse <= '0;
            btn_level <= '0;
        end else begin
            btn_pulse <= cand & (~cand + WIDTH'(1));
            btn_level <= level;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_conditioner
// Purpose  : Self-checking bench for btn_conditioner with a window-based
//            behavioural model plus directed literal timing checks.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_btn_conditioner;

    localparam int         W    = 4;
    localparam int         D    = 4;
    localparam int         DL   = 20;
    localparam int         RT   = 8;
    localparam logic [3:0] MASK = 4'b1010;
    localparam int         MAXK = 4096;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_raw = 4'b0000;
    logic [3:0] btn_pulse;
    logic [3:0] btn_level;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int plog[$];

    always #5 clk = ~clk;

    btn_conditioner #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (DL),
        .REPEAT_RATE    (RT),
        .REPEAT_MASK    (MASK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .btn_pulse(btn_pulse),
        .btn_level(btn_level)
    );

    // Global cycle stamp: number of rising edges seen so far.
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // k counts rising edges since reset release. The synchronised value after
    // edge k is the raw value sampled at edge k-1. The debounced level flips at
    // edge k when the previous D synchronised values all differ from it.
    logic [3:0] rs [MAXK];
    logic [3:0] lv [MAXK];
    int         press_k [W];
    int         k = 0;
    logic [3:0] exp_pulse = 4'b0000;
    logic [3:0] exp_level = 4'b0000;

    function automatic logic [3:0] sync_of(input int idx);
        if (idx < 1) return 4'b0000;
        return rs[idx-1];
    endfunction

    function automatic logic [3:0] lvl_of(input int idx);
        if (idx < 0) return 4'b0000;
        return lv[idx];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [3:0] prev;
        logic [3:0] nxt;
        logic [3:0] s;
        logic [3:0] lk1;
        logic [3:0] lk2;
        logic [3:0] cand;
        bit         all_diff;
        int         d;
        if (!rst_n) begin
            k         = 0;
            exp_pulse = 4'b0000;
            exp_level = 4'b0000;
        end else if (k < MAXK) begin
            rs[k] = btn_raw;
            prev  = lvl_of(k - 1);
            nxt   = prev;
            for (int c = 0; c < W; c++) begin
                all_diff = 1'b1;
                for (int j = 1; j <= D; j++) begin
                    s = sync_of(k - j);
                    if (s[c] == prev[c]) all_diff = 1'b0;
                end
                if (all_diff) nxt[c] = ~prev[c];
            end
            lv[k] = nxt;
            lk1  = lvl_of(k - 1);
            lk2  = lvl_of(k - 2);
            cand = 4'b0000;
            for (int c = 0; c < W; c++) begin
                if (lk1[c] && !lk2[c]) begin
                    cand[c]    = 1'b1;
                    press_k[c] = k;
                end else if (AUTO && MASK[c] && lk1[c]) begin
                    d = k - press_k[c];
                    if (d == DL || (d > DL && (d - DL) % RT == 0)) cand[c] = 1'b1;
                end
            end
            exp_pulse = cand & (~cand + 4'd1);
            exp_level = lk1;
            k++;
        end
    end

    // Compare DUT against the model on every falling edge and log pulses.
    always @(negedge clk) begin
        check($sformatf("pulse@%0d", cyc), btn_pulse, exp_pulse);
        check($sformatf("level@%0d", cyc), btn_level, exp_level);
        if (btn_pulse != 4'b0000) plog.push_back(cyc);
    end

    // ---------------- directed stimulus ----------------
    // Leaves the caller just after the rising edge that makes cyc == c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic check_log(input string name, input int base, input int offs[$]);
        check({name, "_count"}, plog.size(), offs.size());
        for (int i = 0; i < offs.size() && i < plog.size(); i++)
            check($sformatf("%s_%0d", name, i), plog[i], base + offs[i]);
    endtask

    initial begin
        int t0;
        int t1;
        int offs[$];

        rst_n   = 1'b0;
        btn_raw = 4'b0000;
        goto(3);
        rst_n = 1'b1;
        goto(6);
        sample();
        check("reset_pulse", btn_pulse, 4'b0000);
        check("reset_level", btn_level, 4'b0000);

        // Clean press on bit 0, held 50 cycles.
        goto(10);
        plog.delete();
        t0 = cyc;
        btn_raw = 4'b0001;
        goto(t0 + 7);
        sample();
        check("t1_pulse", btn_pulse, 4'b0001);
        check("t1_level", btn_level, 4'b0001);
        sample();
        check("t1_pulse_one_cycle", btn_pulse, 4'b0000);
        goto(t0 + 50);
        btn_raw = 4'b0000;
        t1 = cyc;
        goto(t1 + 6);
        sample();
        check("t1_level_still_high", btn_level, 4'b0001);
        goto(t1 + 7);
        sample();
        check("t1_level_low", btn_level, 4'b0000);
        goto(t1 + 20);
        offs = {};
        offs.push_back(0);
        check_log("t1_log", t0 + 7, offs);

        // Bounce on bit 2: toggle every 2 cycles for 20 cycles, then stable high.
        plog.delete();
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            btn_raw = (i % 2 == 0) ? 4'b0100 : 4'b0000;
            goto(t0 + 2 * (i + 1));
        end
        check("t2_no_bounce_pulse", plog.size(), 0);
        btn_raw = 4'b0100;
        t1 = cyc;
        goto(t1 + 7);
        sample();
        check("t2_pulse", btn_pulse, 4'b0100);
        goto(t1 + 15);
        btn_raw = 4'b0000;
        goto(t1 + 30);
        offs = {};
        offs.push_back(0);
        check_log("t2_log", t1 + 7, offs);

        // Bits 1 and 3 rise together: only bit 1 is issued.
        plog.delete();
        t0 = cyc;
        btn_raw = 4'b1010;
        goto(t0 + 7);
        sample();
        check("t3_pulse", btn_pulse, 4'b0010);
        check("t3_level", btn_level, 4'b1010);
        goto(t0 + 12);
        btn_raw = 4'b0000;
        goto(t0 + 30);
        offs = {};
        offs.push_back(0);
        check_log("t3_log", t0 + 7, offs);

        // Bit 3 held 60 cycles.
        plog.delete();
        t0 = cyc;
        btn_raw = 4'b1000;
        goto(t0 + 60);
        btn_raw = 4'b0000;
        goto(t0 + 100);
        offs = {};
        offs.push_back(0);
        if (AUTO) begin
            offs.push_back(20);
            offs.push_back(28);
            offs.push_back(36);
            offs.push_back(44);
            offs.push_back(52);
        end
        check_log("t4_log", t0 + 7, offs);

        // Reset for 3 cycles while bit 1 is repeating, button kept held.
        plog.delete();
        t0 = cyc;
        btn_raw = 4'b0010;
        goto(t0 + 27);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_pulse", btn_pulse, 4'b0000);
        check("t6_rst_level", btn_level, 4'b0000);
        goto(t0 + 30);
        rst_n = 1'b1;
        t1 = cyc;
        plog.delete();
        goto(t1 + 40);
        offs = {};
        offs.push_back(7);
        if (AUTO) begin
            offs.push_back(27);
            offs.push_back(35);
        end
        check_log("t6_log", t1, offs);
        btn_raw = 4'b0000;
        goto(t1 + 55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end conditioning stage between the four raw board push-buttons and the clock/alarm time-adjust logic. Synchronises each button to `clk`, debounces it, and emits a single-cycle, at-most-one-hot press pulse per accepted press. The adjust logic consumes these pulses as its `btn` input: bit 0 steps the field select forward, bit 2 steps it back, bit 1 decrements and bit 3 increments. Optionally generates auto-repeat pulses on held increment/decrement buttons.

## Interface
- `WIDTH`, 4: number of button channels.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable synchronised samples needed to accept a level change; minimum 1.
- `REPEAT_DELAY`, 50000000: cycles from the initial press pulse to the first repeat pulse; minimum 2.
- `REPEAT_RATE`, 12500000: cycles between subsequent repeat pulses; minimum 2.
- `REPEAT_MASK`, 4'b1010: channels eligible for auto-repeat.

- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  WIDTH  raw, asynchronous, bouncing button levels, active-high.
- `btn_pulse`  out  WIDTH  registered press pulses, one cycle wide, at most one bit set.
- `btn_level`  out  WIDTH  registered debounced button levels.

## Operation
- Reset: all synchroniser flops, debounce counters, debounced levels, repeat state and both outputs clear to 0. Every channel starts in IDLE.
- Synchroniser: two flops per channel. The second flop (`sync`) drives all downstream logic.
- Debounce, per channel:
  - A counter runs while `sync` differs from the debounced level and clears whenever they match.
  - When `sync` has differed for DEBOUNCE_CYCLES consecutive cycles, the debounced level takes `sync` and the counter clears.
  - A bounce mid-count restarts the count from 0.
- Press candidate: generated on a debounced 0->1 transition. No pulse on release.
- Repeat FSM, per channel, for channels whose bit is set in REPEAT_MASK:
  - IDLE: on a debounced rise, raise a candidate, load the timer with REPEAT_DELAY, and go to HELD.
  - HELD: the timer counts down. At expiry, raise a candidate, load REPEAT_RATE, and go to REPEAT.
  - REPEAT: at each expiry, raise a candidate and reload REPEAT_RATE.
  - From HELD or REPEAT: a debounced fall goes to IDLE and clears the timer in the same cycle.
  - Channels not in the mask stay in IDLE and raise a candidate only on a debounced rise.
- Arbitration: if several candidates occur in one cycle, the lowest-index one is issued and the rest are dropped. Dropped candidates are not queued.
- Counter widths are `$clog2(param+1)`. Counters saturate; they never wrap.

## Timing
- Press latency: raw rise sampled at edge 0 gives `sync` high after edge 1.
  - The debounced level rises after edge 1+DEBOUNCE_CYCLES.
  - `btn_level` and `btn_pulse` assert after edge 2+DEBOUNCE_CYCLES.
  - `btn_pulse` holds for exactly one cycle.
- First repeat: the pulse appears REPEAT_DELAY cycles after the initial pulse. Each further repeat follows REPEAT_RATE cycles after the previous one.
- Release latency: `btn_level` falls after edge 2+DEBOUNCE_CYCLES from the first low sample. No repeat pulse is issued after the debounced fall.
- Reset assertion mid-count or mid-repeat clears outputs immediately and asynchronously. Reset deassertion takes effect at the next `clk` edge. A button held through reset release re-debounces and produces one fresh press pulse.

## Configuration
- `BTN_AUTOREPEAT_EN`:
  - Defined: the repeat FSM and timers are compiled in as described above.
  - Undefined: the repeat logic is absent, REPEAT_DELAY, REPEAT_RATE and REPEAT_MASK are ignored, and every channel produces exactly one pulse per accepted press.

## Test plan
Parameters for the bench: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.

- Clean press on bit 0, held 50 cycles then released:
  - `btn_pulse`=4'b0001 for one cycle, 7 cycles after the first high sample.
  - `btn_level[0]` is high from that cycle until 7 cycles after the first low sample.
  - No further pulses.
- Bounce on bit 2, toggling every 2 cycles for 20 cycles then stable high: no pulse during bouncing, then exactly one 4'b0100 pulse 7 cycles after the last edge.
- Bits 1 and 3 rising in the same cycle: one 4'b0010 pulse only. `btn_level`=4'b1010.
- Bit 3 held 60 cycles with BTN_AUTOREPEAT_EN defined: pulses at t, t+20, t+28, t+36, t+44, t+52 (with t the first pulse cycle). None after release.
- Same stimulus with BTN_AUTOREPEAT_EN undefined: a single pulse at t.
- `rst_n` low for 3 cycles while bit 1 is repeating:
  - Outputs read 0 immediately.
  - After release, with the button still held, one fresh pulse arrives 7 cycles after reset deassertion, followed by repeats at +20.
